// File: rtl/regfile_pkg.sv
// Shared constants and register-map helpers for the channel register file.
package regfile_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;

    // Requester indices; index 0 has fixed top priority.
    localparam int unsigned REQ_SPI = 0;
    localparam int unsigned REQ_MC  = 1;
    localparam int unsigned REQ_AUX = 2;

    // Register map: per-channel blocks of CH_STRIDE bytes.
    localparam int CH_STRIDE      = 4;
    localparam int FLAGS_POS_BASE = 0;
    localparam int SPEED_TGT_BASE = 64;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_kind_e;

    function automatic logic [ADDR_W-1:0] flags_pos_addr(input logic [3:0] ch);
        return ADDR_W'(FLAGS_POS_BASE + int'(ch) * CH_STRIDE);
    endfunction

    function automatic logic [ADDR_W-1:0] speed_tgt_addr(input logic [3:0] ch);
        return ADDR_W'(SPEED_TGT_BASE + int'(ch) * CH_STRIDE);
    endfunction

endpackage

// File: rtl/regfile_rr_pick.sv
// Combinational round-robin picker over requesters 1..N-1 (bit 0 ignored).
// Search starts at i_ptr and wraps from N-1 back to 1.
module regfile_rr_pick
    import regfile_pkg::*;
#(
    parameter int N     = 3,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_valid
);

    logic [N-1:0] w_cand;
    logic [N-1:0] w_upper;
    logic [N-1:0] w_sel;

    // Candidates are requesters 1..N-1; prefer those at or above the pointer,
    // otherwise wrap to the lowest candidate, then isolate the lowest set bit.
    assign w_cand  = {i_req[N-1:1], 1'b0};
    assign w_upper = w_cand & ~((N'(1) << i_ptr) - N'(1));
    assign w_sel   = (|w_upper) ? w_upper : w_cand;
    assign o_gnt   = w_sel & (~w_sel + N'(1));
    assign o_valid = |w_cand;

endmodule

// File: rtl/regfile_arbiter.sv
// Arbiter and storage for the shared 128x8 channel register file.
// Requester 0 has fixed priority, others round-robin; a bounded lock makes
// multi-byte bursts atomic.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int LOCK_MAX = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      owner_valid,
    output logic [$clog2(N_REQ)-1:0]  owner_id,
    output logic                      lock_abort
);

    localparam int ID_W      = $clog2(N_REQ);
    localparam int CNT_W     = $clog2(LOCK_MAX + 1);
    localparam int MEM_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic [N_REQ-1:0]  r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_owner_valid;
    logic [ID_W-1:0]   r_owner_id;
    logic              r_lock_abort;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_lock_cnt;

    logic [ADDR_W-1:0] w_addr  [N_REQ];
    logic [DATA_W-1:0] w_wdata [N_REQ];

    logic [N_REQ-1:0]  w_rr_gnt;
    logic              w_rr_valid;
    logic [N_REQ-1:0]  w_gnt_raw;
    logic [ID_W-1:0]   w_sel_id;
    logic              w_fire;
    acc_kind_e         w_sel_kind;
    logic              w_sel_lock;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_acquire;
    logic              w_release;
    logic              w_timeout;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr[g]  = addr[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = wdata[g*DATA_W +: DATA_W];
    end

    regfile_rr_pick #(
        .N     (N_REQ),
        .PTR_W (ID_W)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_rr_gnt),
        .o_valid (w_rr_valid)
    );

    // Grant selection: a lock owner excludes everyone, else SPI, else round-robin.
    always_comb begin
        w_gnt_raw = '0;
        if (r_owner_valid) begin
            w_gnt_raw[r_owner_id] = req[r_owner_id];
        end else if (req[REQ_SPI]) begin
            w_gnt_raw[REQ_SPI] = 1'b1;
        end else if (w_rr_valid) begin
            w_gnt_raw = w_rr_gnt;
        end
    end

    // Encode the one-hot grant into the index of the winning requester.
    always_comb begin
        w_sel_id = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_gnt_raw[i]) begin
                w_sel_id = ID_W'(i);
            end
        end
    end

    assign gnt         = resetn ? w_gnt_raw : '0;
    assign w_fire      = |gnt;
    assign w_sel_kind  = we[w_sel_id] ? ACC_WRITE : ACC_READ;
    assign w_sel_lock  = lock[w_sel_id];
    assign w_sel_addr  = w_addr[w_sel_id];
    assign w_sel_wdata = w_wdata[w_sel_id];

    assign w_acquire = !r_owner_valid && w_fire && w_sel_lock;
    assign w_release = r_owner_valid && w_fire && !w_sel_lock;
    assign w_timeout = r_owner_valid && !w_release &&
                       (r_lock_cnt == CNT_W'(LOCK_MAX - 1));

    // Storage array kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_fire && w_sel_kind == ACC_WRITE) begin
            r_mem[w_sel_addr] <= w_sel_wdata;
        end
    end

    // Read return, round-robin pointer and lock ownership/timeout tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid      <= '0;
            r_rdata       <= '0;
            r_owner_valid <= 1'b0;
            r_owner_id    <= '0;
            r_lock_abort  <= 1'b0;
            r_rr_ptr      <= ID_W'(1);
            r_lock_cnt    <= '0;
        end else begin
            r_rvalid     <= '0;
            r_lock_abort <= 1'b0;

            if (w_fire && w_sel_kind == ACC_READ) begin
                r_rvalid <= gnt;
                r_rdata  <= r_mem[w_sel_addr];
            end

            if (w_fire && w_sel_id != ID_W'(REQ_SPI)) begin
                r_rr_ptr <= (w_sel_id == ID_W'(N_REQ - 1)) ? ID_W'(1)
                                                            : w_sel_id + ID_W'(1);
            end

            // A releasing beat on the timeout edge wins: normal release, no abort.
            if (w_acquire) begin
                r_owner_valid <= 1'b1;
                r_owner_id    <= w_sel_id;
                r_lock_cnt    <= '0;
            end else if (w_release) begin
                r_owner_valid <= 1'b0;
                r_lock_cnt    <= '0;
            end else if (w_timeout) begin
                r_owner_valid <= 1'b0;
                r_lock_abort  <= 1'b1;
                r_lock_cnt    <= '0;
            end else if (r_owner_valid) begin
                r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            end
        end
    end

    assign rvalid      = r_rvalid;
    assign rdata       = r_rdata;
    assign owner_valid = r_owner_valid;
    assign owner_id    = r_owner_id;
    assign lock_abort  = r_lock_abort;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: read/write, priority, round-robin,
// locked bursts, lock timeout, reset mid-burst, release on the timeout edge.
module tb_regfile_arbiter;

    localparam int N_REQ    = 3;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 8;

    logic                    clk;
    logic                    resetn;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic                    owner_valid;
    logic [1:0]              owner_id;
    logic                    lock_abort;

    int n_pass;
    int n_total;

    regfile_arbiter #(
        .N_REQ    (N_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .we          (we),
        .lock        (lock),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .owner_valid (owner_valid),
        .owner_id    (owner_id),
        .lock_abort  (lock_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drv(input int unsigned i, input logic r, input logic w, input logic l,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i]                  = r;
        we[i]                   = w;
        lock[i]                 = l;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_exp [4];

    initial begin
        n_pass  = 0;
        n_total = 0;
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        resetn = 1'b0;

        // Reset state, and grant forced low even with requests present
        tick();
        req = 3'b111;
        #1;
        chk("rst_gnt",         32'(gnt),         32'h0);
        chk("rst_rvalid",      32'(rvalid),      32'h0);
        chk("rst_rdata",       32'(rdata),       32'h0);
        chk("rst_owner_valid", 32'(owner_valid), 32'h0);
        chk("rst_owner_id",    32'(owner_id),    32'h0);
        chk("rst_lock_abort",  32'(lock_abort),  32'h0);
        req = '0;
        tick();
        resetn = 1'b1;
        tick();

        // Write then read by requester 1
        drv(1, 1, 1, 0, 7'h05, 8'hA5);
        #1 chk("wr_gnt", 32'(gnt), 32'h2);
        tick();
        drv(1, 1, 0, 0, 7'h05, 8'h00);
        #1 chk("rd_gnt", 32'(gnt), 32'h2);
        tick();
        chk("rd_rvalid", 32'(rvalid), 32'h2);
        chk("rd_rdata",  32'(rdata),  32'hA5);
        drv(1, 0, 0, 0, 7'h00, 8'h00);
        #1 chk("idle_gnt", 32'(gnt), 32'h0);
        tick();
        chk("idle_rvalid", 32'(rvalid), 32'h0);
        chk("hold_rdata",  32'(rdata),  32'hA5);

        // Priority: all three held -> requester 0 every cycle
        drv(0, 1, 0, 0, 7'h05, 8'h00);
        drv(1, 1, 0, 0, 7'h05, 8'h00);
        drv(2, 1, 0, 0, 7'h05, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1 chk("prio_gnt0", 32'(gnt), 32'h1);
            tick();
        end
        // Pointer is 2 after the last grant to 1; grant to 0 left it there
        drv(0, 0, 0, 0, 7'h00, 8'h00);
        rr_exp[0] = 3'b100; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b010;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
            tick();
        end
        drv(1, 0, 0, 0, 7'h00, 8'h00);
        drv(2, 0, 0, 0, 7'h00, 8'h00);
        tick();

        // Atomic 4-byte burst by requester 1 while SPI waits
        drv(1, 1, 1, 1, 7'h00, 8'h11);
        #1 chk("burst1_gnt", 32'(gnt), 32'h2);
        tick();
        chk("burst_owner_valid", 32'(owner_valid), 32'h1);
        chk("burst_owner_id",    32'(owner_id),    32'h1);
        drv(0, 1, 0, 0, 7'h01, 8'h00);
        drv(1, 1, 1, 1, 7'h01, 8'h22);
        #1 chk("burst2_gnt", 32'(gnt), 32'h2);
        tick();
        chk("burst2_owner", 32'(owner_valid), 32'h1);
        drv(1, 1, 1, 1, 7'h02, 8'h33);
        #1 chk("burst3_gnt", 32'(gnt), 32'h2);
        tick();
        chk("burst3_owner", 32'(owner_valid), 32'h1);
        drv(1, 1, 1, 0, 7'h03, 8'h44);
        #1 chk("burst4_gnt", 32'(gnt), 32'h2);
        tick();
        chk("burst_end_owner", 32'(owner_valid), 32'h0);
        chk("burst_end_abort", 32'(lock_abort),  32'h0);
        drv(1, 0, 0, 0, 7'h00, 8'h00);
        #1 chk("spi_after_burst_gnt", 32'(gnt), 32'h1);
        tick();
        chk("spi_rd1_rvalid", 32'(rvalid), 32'h1);
        chk("spi_rd1_rdata",  32'(rdata),  32'h22);
        drv(0, 1, 0, 0, 7'h02, 8'h00);
        tick();
        chk("spi_rd2_rdata", 32'(rdata), 32'h33);
        drv(0, 1, 0, 0, 7'h03, 8'h00);
        tick();
        chk("spi_rd3_rdata", 32'(rdata), 32'h44);
        drv(0, 0, 0, 0, 7'h00, 8'h00);
        tick();

        // Lock timeout: owner locks once and goes quiet, SPI waits
        drv(1, 1, 0, 1, 7'h10, 8'h00);
        #1 chk("to_acq_gnt", 32'(gnt), 32'h2);
        tick();
        drv(1, 0, 0, 0, 7'h00, 8'h00);
        drv(0, 1, 0, 0, 7'h05, 8'h00);
        for (int k = 1; k <= LOCK_MAX; k++) begin
            #1;
            chk("to_wait_gnt",   32'(gnt),         32'h0);
            chk("to_wait_owner", 32'(owner_valid), 32'h1);
            chk("to_wait_abort", 32'(lock_abort),  32'h0);
            tick();
        end
        chk("to_abort",       32'(lock_abort),  32'h1);
        chk("to_owner_clear", 32'(owner_valid), 32'h0);
        chk("to_spi_gnt",     32'(gnt),         32'h1);
        tick();
        chk("to_abort_pulse_end", 32'(lock_abort), 32'h0);
        chk("to_spi_rdata",       32'(rdata),      32'hA5);
        drv(0, 0, 0, 0, 7'h00, 8'h00);
        tick();

        // Reset in the middle of a locked burst
        drv(1, 1, 1, 1, 7'h30, 8'h77);
        tick();
        drv(1, 1, 0, 1, 7'h30, 8'h00);
        tick();
        chk("mid_pre_owner", 32'(owner_valid), 32'h1);
        chk("mid_pre_rdata", 32'(rdata),       32'h77);
        resetn = 1'b0;
        #1;
        chk("mid_rst_gnt",    32'(gnt),         32'h0);
        chk("mid_rst_rvalid", 32'(rvalid),      32'h0);
        chk("mid_rst_owner",  32'(owner_valid), 32'h0);
        chk("mid_rst_rdata",  32'(rdata),       32'h0);
        tick();
        resetn = 1'b1;
        drv(1, 1, 0, 0, 7'h30, 8'h00);
        drv(2, 1, 0, 0, 7'h05, 8'h00);
        #1 chk("post_rst_ptr_gnt", 32'(gnt), 32'h2);
        tick();
        chk("post_rst_rvalid",  32'(rvalid), 32'h2);
        chk("mem_kept_rdata",   32'(rdata),  32'h77);
        drv(1, 0, 0, 0, 7'h00, 8'h00);
        #1 chk("post_rst_gnt2", 32'(gnt), 32'h4);
        tick();
        chk("post_rst_rvalid2", 32'(rvalid), 32'h4);
        chk("post_rst_rdata2",  32'(rdata),  32'hA5);
        drv(2, 0, 0, 0, 7'h00, 8'h00);
        tick();

        // Final unlocking beat lands exactly on the timeout cycle
        drv(1, 1, 1, 1, 7'h40, 8'h01);
        #1 chk("sim_acq_gnt", 32'(gnt), 32'h2);
        tick();
        drv(1, 0, 0, 0, 7'h00, 8'h00);
        for (int k = 1; k < LOCK_MAX; k++) begin
            #1 chk("sim_hold_owner", 32'(owner_valid), 32'h1);
            tick();
        end
        drv(1, 1, 1, 0, 7'h41, 8'h02);
        #1 chk("sim_rel_gnt", 32'(gnt), 32'h2);
        tick();
        chk("sim_owner_clear", 32'(owner_valid), 32'h0);
        chk("sim_no_abort",    32'(lock_abort),  32'h0);
        drv(1, 0, 0, 0, 7'h00, 8'h00);
        drv(0, 1, 0, 0, 7'h41, 8'h00);
        #1 chk("sim_spi_gnt", 32'(gnt), 32'h1);
        tick();
        chk("sim_no_abort2", 32'(lock_abort), 32'h0);
        chk("sim_rd_rdata",  32'(rdata),      32'h02);
        drv(0, 0, 0, 0, 7'h00, 8'h00);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
